// File: rtl/split_sum_acc.sv
// split_sum_acc: accumulates N split 24-bit samples {a,b} per block with sticky overflow.
// Define SPLIT_SUM_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module split_sum_acc #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] acc_hi,
    output logic [11:0] acc_lo,
    output logic        overflow
);
    localparam logic ACCUM = 1'b0;
    localparam logic DONE  = 1'b1;

    logic        r_state;
    logic [7:0]  r_count;
    logic [23:0] r_acc;
    logic        r_ovf;
    logic [24:0] w_sum;
    logic [23:0] w_acc_nxt;
    logic        w_in_hs;
    logic        w_out_hs;
    logic        w_last;

    assign w_sum = {1'b0, r_acc} + {1'b0, a, b};
`ifdef SPLIT_SUM_SAT_EN
    assign w_acc_nxt = w_sum[24] ? 24'hFFFFFF : w_sum[23:0];
`else
    assign w_acc_nxt = w_sum[23:0];
`endif
    assign w_in_hs  = in_valid && r_state == ACCUM;
    assign w_out_hs = out_ready && r_state == DONE;
    assign w_last   = r_count == 8'(N - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ACCUM;
            r_count <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_out_hs) begin
            r_state <= ACCUM;
            r_count <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_in_hs) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + 8'd1;
            r_ovf   <= r_ovf | w_sum[24];
            r_state <= w_last ? DONE : ACCUM;
        end
    end

    assign in_ready  = r_state == ACCUM;
    assign out_valid = r_state == DONE;
    assign acc_hi    = r_acc[23:12];
    assign acc_lo    = r_acc[11:0];
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_split_sum_acc.sv
// tb_split_sum_acc: table-driven check of the N=4 build plus directed N=1/2/3 sequences.
module tb_split_sum_acc;
    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [11:0] a, b;
    logic        ir4, ov4, of4, ir2, ov2, of2, ir3, ov3, of3, ir1, ov1, of1;
    logic [11:0] hi4, lo4, hi2, lo2, hi3, lo3, hi1, lo1;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

`ifdef SPLIT_SUM_SAT_EN
    localparam logic [23:0] E7 = 24'hFFFFFF, E8 = 24'hFFFFFF, E9 = 24'hFFFFFF;
`else
    localparam logic [23:0] E7 = 24'hFFFFFE, E8 = 24'hFFFFFD, E9 = 24'hFFFFFC;
`endif

    split_sum_acc #(.N(4)) u4 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
        .a(a), .b(b), .out_valid(ov4), .out_ready(out_ready), .acc_hi(hi4), .acc_lo(lo4), .overflow(of4));
    split_sum_acc #(.N(2)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
        .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready), .acc_hi(hi2), .acc_lo(lo2), .overflow(of2));
    split_sum_acc #(.N(3)) u3 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3),
        .a(a), .b(b), .out_valid(ov3), .out_ready(out_ready), .acc_hi(hi3), .acc_lo(lo3), .overflow(of3));
    split_sum_acc #(.N(1)) u1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .acc_hi(hi1), .acc_lo(lo1), .overflow(of1));

    typedef struct {
        logic        rst;
        logic        iv;
        logic [11:0] a;
        logic [11:0] b;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic [23:0] eacc;
        logic        eovf;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [11:0] va, input logic [11:0] vb,
                        input logic ordy);
        reset = r; in_valid = iv; a = va; b = vb; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        vecs[0]  = '{1, 0, 12'h000, 12'h000, 0, 0, 1, 24'h000000, 0};
        vecs[1]  = '{0, 1, 12'h000, 12'h001, 1, 0, 1, 24'h000001, 0};
        vecs[2]  = '{0, 1, 12'h000, 12'h002, 1, 0, 1, 24'h000003, 0};
        vecs[3]  = '{0, 1, 12'h000, 12'h003, 1, 0, 1, 24'h000006, 0};
        vecs[4]  = '{0, 1, 12'h000, 12'h004, 1, 1, 0, 24'h00000A, 0};
        vecs[5]  = '{0, 0, 12'h000, 12'h000, 1, 0, 1, 24'h000000, 0};
        vecs[6]  = '{0, 1, 12'hFFF, 12'hFFF, 0, 0, 1, 24'hFFFFFF, 0};
        vecs[7]  = '{0, 1, 12'hFFF, 12'hFFF, 0, 0, 1, E7, 1};
        vecs[8]  = '{0, 1, 12'hFFF, 12'hFFF, 0, 0, 1, E8, 1};
        vecs[9]  = '{0, 1, 12'hFFF, 12'hFFF, 0, 1, 0, E9, 1};
        for (int i = 10; i < 15; i++) vecs[i] = '{0, 1, 12'h123, 12'h456, 0, 1, 0, E9, 1};
        vecs[15] = '{0, 1, 12'h123, 12'h456, 1, 0, 1, 24'h000000, 0};
        vecs[16] = '{0, 1, 12'h000, 12'h005, 0, 0, 1, 24'h000005, 0};
        vecs[17] = '{0, 1, 12'h000, 12'h005, 0, 0, 1, 24'h00000A, 0};
        vecs[18] = '{1, 1, 12'h000, 12'h005, 1, 0, 1, 24'h000000, 0};
        vecs[19] = '{0, 1, 12'h000, 12'h001, 0, 0, 1, 24'h000001, 0};
        vecs[20] = '{0, 1, 12'h000, 12'h001, 0, 0, 1, 24'h000002, 0};
        vecs[21] = '{0, 1, 12'h000, 12'h001, 0, 0, 1, 24'h000003, 0};
        vecs[22] = '{0, 1, 12'h000, 12'h001, 0, 1, 0, 24'h000004, 0};
        vecs[23] = '{1, 0, 12'h000, 12'h000, 1, 0, 1, 24'h000000, 0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ordy);
            chk($sformatf("row%0d_out_valid", i), 24'(ov4), 24'(vecs[i].eov));
            chk($sformatf("row%0d_in_ready", i), 24'(ir4), 24'(vecs[i].eir));
            chk($sformatf("row%0d_acc", i), {hi4, lo4}, vecs[i].eacc);
            chk($sformatf("row%0d_overflow", i), 24'(of4), 24'(vecs[i].eovf));
        end
        // N=2: carry from the low word into the high word
        step(1, 0, 12'h000, 12'h000, 0);
        step(0, 1, 12'h000, 12'hFFF, 0);
        chk("n2_first_valid", 24'(ov2), 24'h0);
        chk("n2_first_acc", {hi2, lo2}, 24'h000FFF);
        step(0, 1, 12'h000, 12'hFFF, 0);
        chk("n2_valid", 24'(ov2), 24'h1);
        chk("n2_in_ready", 24'(ir2), 24'h0);
        chk("n2_acc", {hi2, lo2}, 24'h001FFE);
        chk("n2_overflow", 24'(of2), 24'h0);
        step(0, 0, 12'h000, 12'h000, 1);
        chk("n2_drain_valid", 24'(ov2), 24'h0);
        chk("n2_drain_ready", 24'(ir2), 24'h1);
        // N=3: idle cycles between samples are not counted
        step(1, 0, 12'h000, 12'h000, 0);
        step(0, 1, 12'h000, 12'h005, 0);
        chk("n3_gap1_valid", 24'(ov3), 24'h0);
        step(0, 0, 12'h000, 12'hABC, 0);
        chk("n3_gap2_valid", 24'(ov3), 24'h0);
        chk("n3_gap2_acc", {hi3, lo3}, 24'h000005);
        step(0, 1, 12'h000, 12'h007, 0);
        chk("n3_gap3_valid", 24'(ov3), 24'h0);
        step(0, 0, 12'h000, 12'hABC, 0);
        chk("n3_gap4_valid", 24'(ov3), 24'h0);
        step(0, 1, 12'h000, 12'h009, 0);
        chk("n3_valid", 24'(ov3), 24'h1);
        chk("n3_acc", {hi3, lo3}, 24'h000015);
        step(0, 1, 12'h000, 12'h009, 0);
        chk("n3_hold_acc", {hi3, lo3}, 24'h000015);
        // N=1: every sample is its own block
        step(1, 0, 12'h000, 12'h000, 0);
        step(0, 1, 12'h000, 12'h00A, 0);
        chk("n1_valid", 24'(ov1), 24'h1);
        chk("n1_acc", {hi1, lo1}, 24'h00000A);
        step(0, 1, 12'h000, 12'h003, 1);
        chk("n1_drain_valid", 24'(ov1), 24'h0);
        chk("n1_drain_acc", {hi1, lo1}, 24'h000000);
        step(0, 1, 12'h000, 12'h003, 0);
        chk("n1_second_valid", 24'(ov1), 24'h1);
        chk("n1_second_acc", {hi1, lo1}, 24'h000003);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/split_sum_acc.md
SPLIT_SUM_ACC -- requirements
Module: split_sum_acc

Interface
REQ-001 The block SHALL have one parameter: N, default 4, the number of accepted samples per block (legal range 1..255).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the upstream sample is present.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-006 The block SHALL have the port a, input, 12 bits: high word of the upstream 24-bit sum.
REQ-007 The block SHALL have the port b, input, 12 bits: low word of the upstream 24-bit sum.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: the block result is present.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: downstream takes the result.
REQ-010 The block SHALL have the port acc_hi, output, 12 bits: accumulator bits [23:12].
REQ-011 The block SHALL have the port acc_lo, output, 12 bits: accumulator bits [11:0].
REQ-012 The block SHALL have the port overflow, output, 1 bit: sticky flag for the current block, set on carry out of bit 23.

Function
REQ-013 The sample value SHALL be {a,b} as an unsigned 24-bit number, with a as the MSBs.
REQ-014 An input handshake SHALL occur when in_valid and in_ready are both 1 on a rising edge; acc <= acc + {a,b} and count <= count + 1.
REQ-015 The FSM SHALL have two states: ACCUM, where in_ready=1 and out_valid=0, and DONE, where in_ready=0 and out_valid=1.
REQ-016 In ACCUM, the handshake that makes count reach N SHALL move the FSM to DONE on the same edge; out_valid SHALL rise the following cycle, and acc_hi/acc_lo SHALL include that Nth sample.
REQ-017 In ACCUM, a cycle with in_valid=0 SHALL leave acc, count and overflow unchanged.
REQ-018 In DONE, acc_hi, acc_lo and overflow SHALL stay stable until an output handshake (out_valid and out_ready both 1).
REQ-019 In DONE, in_valid SHALL be ignored.
REQ-020 An output handshake SHALL clear acc, count and overflow to 0 and return the FSM to ACCUM, so in_ready=1 on the next cycle.
REQ-021 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-022 The overflow flag SHALL be set when the 25-bit sum acc + {a,b} has bit 24 set, and SHALL remain set until the output handshake or reset.
REQ-023 When N=1, every accepted sample SHALL produce a result on its own.
REQ-024 When overflow is set, acc_hi/acc_lo SHALL take the value defined by the Configuration section.

Reset
REQ-025 When reset=1 on a rising edge, the block SHALL set state=ACCUM, acc=0, count=0, overflow=0, out_valid=0 and in_ready=1 from the next cycle.
REQ-026 Reset SHALL take priority over any simultaneous input or output handshake.
REQ-027 A reset in mid-block SHALL discard any partial accumulation with no result emitted.

Configuration
REQ-028 With the macro SPLIT_SUM_SAT_EN defined, the accumulator SHALL saturate: on any overflowing add, acc becomes 24'hFFFFFF and further adds within the block keep it at 24'hFFFFFF.
REQ-029 Without SPLIT_SUM_SAT_EN, the accumulator SHALL wrap modulo 2^24.
REQ-030 The overflow flag SHALL behave identically whether or not SPLIT_SUM_SAT_EN is defined.

Verification
REQ-031 The bench SHALL cover the basic case: N=4, samples {a,b} = {0,1},{0,2},{0,3},{0,4} on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after the 4th handshake, acc_hi=0x000, acc_lo=0x00A, overflow=0.
REQ-032 The bench SHALL cover carry across words: N=2, samples {0x000,0xFFF} twice -> acc_hi=0x001, acc_lo=0xFFE, overflow=0.
REQ-033 The bench SHALL cover overflow: N=4, four samples {0xFFF,0xFFF} -> overflow=1, and {acc_hi,acc_lo}=0xFFFFFC without SPLIT_SUM_SAT_EN or 0xFFFFFF with it.
REQ-034 The bench SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE while in_valid=1 -> in_ready=0, outputs unchanged. When out_ready=1, out_valid=0 and in_ready=1 on the next cycle, and the next block starts from 0.
REQ-035 The bench SHALL cover input gaps: N=3, in_valid toggling 1,0,1,0,1 with samples 5,7,9 -> a single result of 0x000/0x015, with the 0-cycles not counted.
REQ-036 The bench SHALL cover reset mid-block: N=4, two samples accepted, then reset=1 for one cycle, then four samples of value 1 -> result 0x000/0x004 with no earlier out_valid pulse.
